// File: rtl/hazard_scoreboard.sv
// Stall/forward controller for the 5-stage pipeline: age-ordered writer scoreboard (E..W)
// plus an MDU busy counter, evaluated against the instruction currently in D.
module hazard_scoreboard #(
    parameter int NSTAGE   = 3,
    parameter int AW       = 5,
    parameter int TW       = 2,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int FW       = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          d_valid,
    input  logic [AW-1:0] d_rs,
    input  logic [AW-1:0] d_rt,
    input  logic [TW-1:0] d_tuse_rs,
    input  logic [TW-1:0] d_tuse_rt,
    input  logic [AW-1:0] d_wa,
    input  logic [TW-1:0] d_tnew,
    input  logic          d_md,
    input  logic          d_div,
    input  logic          d_mhl,
    input  logic          flush,
    output logic          stall,
    output logic [FW-1:0] fwd_rs_sel,
    output logic [FW-1:0] fwd_rt_sel,
    output logic          md_busy
);

    localparam int MCW = $clog2(DIV_LAT + 1);
    localparam logic [TW-1:0] TUSE_NONE = '1;

    logic [NSTAGE-1:0] v_reg;
    logic [AW-1:0]     wa_reg   [NSTAGE];
    logic [TW-1:0]     tnew_reg [NSTAGE];
    logic [MCW-1:0]    md_cnt_reg;

    logic [NSTAGE-1:0] match_rs;
    logic [NSTAGE-1:0] match_rt;

    logic          hit_rs, hit_rt;
    logic [TW-1:0] tnew_rs, tnew_rt;
    logic [FW-1:0] sel_rs, sel_rt;
    logic          stall_rs, stall_rt, stall_md;
    logic          md_issue;

    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NSTAGE; gi++) begin : g_match
            assign match_rs[gi] = v_reg[gi] && (wa_reg[gi] == d_rs) && (d_rs != '0);
            assign match_rt[gi] = v_reg[gi] && (wa_reg[gi] == d_rt) && (d_rt != '0);
        end
    endgenerate

    // Scan oldest to youngest so the youngest matching writer is the one left standing.
    always_comb begin
        hit_rs  = 1'b0;
        tnew_rs = '0;
        sel_rs  = '0;
        hit_rt  = 1'b0;
        tnew_rt = '0;
        sel_rt  = '0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (match_rs[k]) begin
                hit_rs  = 1'b1;
                tnew_rs = tnew_reg[k];
                sel_rs  = FW'(k + 1);
            end
            if (match_rt[k]) begin
                hit_rt  = 1'b1;
                tnew_rt = tnew_reg[k];
                sel_rt  = FW'(k + 1);
            end
        end
    end

    assign stall_rs = (d_tuse_rs != TUSE_NONE) && hit_rs && (tnew_rs > d_tuse_rs);
    assign stall_rt = (d_tuse_rt != TUSE_NONE) && hit_rt && (tnew_rt > d_tuse_rt);
    assign stall_md = d_valid && (d_md || d_mhl) && (md_cnt_reg != '0);
    assign stall    = d_valid && (stall_rs || stall_rt || stall_md);

    assign fwd_rs_sel = (hit_rs && (tnew_rs == '0)) ? sel_rs : '0;
    assign fwd_rt_sel = (hit_rt && (tnew_rt == '0)) ? sel_rt : '0;

    assign md_busy  = (md_cnt_reg != '0);
    assign md_issue = d_valid && d_md && !stall && !flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_reg      <= '0;
            md_cnt_reg <= '0;
            for (int k = 0; k < NSTAGE; k++) begin
                wa_reg[k]   <= '0;
                tnew_reg[k] <= '0;
            end
        end else begin
            // A stalled or flushed D instruction enters E as a bubble.
            v_reg[0]    <= d_valid && !stall && !flush && (d_wa != '0);
            wa_reg[0]   <= d_wa;
            tnew_reg[0] <= d_tnew;
            for (int k = 1; k < NSTAGE; k++) begin
                v_reg[k]    <= v_reg[k-1] && (!flush || (k == NSTAGE - 1));
                wa_reg[k]   <= wa_reg[k-1];
                tnew_reg[k] <= sat_dec(tnew_reg[k-1]);
            end
            // Reload only from idle so the counter can never wrap or be cut short.
            if (md_issue && (md_cnt_reg == '0)) begin
                md_cnt_reg <= d_div ? MCW'(DIV_LAT) : MCW'(MULT_LAT);
            end else if (md_cnt_reg != '0) begin
                md_cnt_reg <= md_cnt_reg - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use, branch forwarding, $0, youngest-wins,
// MDU occupancy, flush and asynchronous reset, with hand-computed expectations.
module tb_hazard_scoreboard;

    logic       clk;
    logic       reset;
    logic       d_valid;
    logic [4:0] d_rs, d_rt, d_wa;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_md, d_div, d_mhl, flush;
    logic       stall, md_busy;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;

    int compared   = 0;
    int mismatched = 0;

    hazard_scoreboard dut (
        .clk        (clk),
        .reset      (reset),
        .d_valid    (d_valid),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_tuse_rs  (d_tuse_rs),
        .d_tuse_rt  (d_tuse_rt),
        .d_wa       (d_wa),
        .d_tnew     (d_tnew),
        .d_md       (d_md),
        .d_div      (d_div),
        .d_mhl      (d_mhl),
        .flush      (flush),
        .stall      (stall),
        .fwd_rs_sel (fwd_rs_sel),
        .fwd_rt_sel (fwd_rt_sel),
        .md_busy    (md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic set_d(input int valid, input int rs, input int tuse_rs, input int rt,
                         input int tuse_rt, input int wa, input int tnew,
                         input int md, input int dv, input int mhl);
        d_valid   = 1'(valid);
        d_rs      = 5'(rs);
        d_tuse_rs = 2'(tuse_rs);
        d_rt      = 5'(rt);
        d_tuse_rt = 2'(tuse_rt);
        d_wa      = 5'(wa);
        d_tnew    = 2'(tnew);
        d_md      = 1'(md);
        d_div     = 1'(dv);
        d_mhl     = 1'(mhl);
        #1;
    endtask

    task automatic nop();
        set_d(0, 0, 3, 0, 3, 0, 0, 0, 0, 0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        nop();
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        reset = 1'b0;
        flush = 1'b0;
        set_d(1, 0, 3, 0, 3, 0, 0, 0, 0, 1);
        check("rst_stall", 8'(stall), 8'd0);
        check("rst_fwd_rs", 8'(fwd_rs_sel), 8'd0);
        check("rst_fwd_rt", 8'(fwd_rt_sel), 8'd0);
        check("rst_md_busy", 8'(md_busy), 8'd0);
        cyc();
        cyc();
        reset = 1'b1;
        idle(1);

        // lw $1 then dependent addu (tuse=1): one stall cycle
        set_d(1, 0, 3, 0, 3, 1, 2, 0, 0, 0);
        check("t1_lw_stall", 8'(stall), 8'd0);
        cyc();
        set_d(1, 1, 1, 0, 3, 4, 1, 0, 0, 0);
        check("t1_use_stall_c1", 8'(stall), 8'd1);
        cyc();
        check("t1_use_stall_c2", 8'(stall), 8'd0);
        cyc();
        idle(3);

        // addu $2 then beq on $2: stall once, then forward from M
        set_d(1, 0, 3, 0, 3, 2, 1, 0, 0, 0);
        cyc();
        set_d(1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        check("t2_stall_c1", 8'(stall), 8'd1);
        check("t2_fwd_c1", 8'(fwd_rs_sel), 8'd0);
        cyc();
        check("t2_stall_c2", 8'(stall), 8'd0);
        check("t2_fwd_m", 8'(fwd_rs_sel), 8'd2);
        cyc();
        idle(3);

        // writer of $0 never hazards
        set_d(1, 0, 3, 0, 3, 0, 2, 0, 0, 0);
        cyc();
        set_d(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("t3_stall", 8'(stall), 8'd0);
        check("t3_fwd_rs", 8'(fwd_rs_sel), 8'd0);
        cyc();
        check("t3_stall_c2", 8'(stall), 8'd0);
        idle(3);

        // older $3 ready in M, younger $3 not ready in E: younger wins
        set_d(1, 0, 3, 0, 3, 3, 1, 0, 0, 0);
        cyc();
        set_d(1, 0, 3, 0, 3, 3, 1, 0, 0, 0);
        cyc();
        set_d(1, 3, 0, 0, 3, 0, 0, 0, 0, 0);
        check("t4_stall", 8'(stall), 8'd1);
        check("t4_no_fwd_m", 8'(fwd_rs_sel), 8'd0);
        cyc();
        check("t4_stall_c2", 8'(stall), 8'd0);
        check("t4_fwd_young_m", 8'(fwd_rs_sel), 8'd2);
        cyc();
        idle(3);

        // rt forwarding from E and from W; tnew==tuse does not stall
        set_d(1, 0, 3, 0, 3, 6, 0, 0, 0, 0);
        cyc();
        set_d(1, 0, 3, 6, 0, 0, 0, 0, 0, 0);
        check("t5_fwd_rt_e", 8'(fwd_rt_sel), 8'd1);
        check("t5_stall_e", 8'(stall), 8'd0);
        cyc();
        nop();
        cyc();
        set_d(1, 0, 3, 6, 0, 0, 0, 0, 0, 0);
        check("t5_fwd_rt_w", 8'(fwd_rt_sel), 8'd3);
        cyc();
        idle(3);
        set_d(1, 0, 3, 0, 3, 7, 2, 0, 0, 0);
        cyc();
        set_d(1, 7, 3, 7, 2, 0, 0, 0, 0, 0);
        check("t5_tuse_eq_tnew", 8'(stall), 8'd0);
        check("t5_fwd_rt_notready", 8'(fwd_rt_sel), 8'd0);
        cyc();
        idle(3);

        // mult then mflo: 5 busy/stall cycles
        set_d(1, 0, 3, 0, 3, 0, 0, 1, 0, 0);
        check("t6_mult_issue_stall", 8'(stall), 8'd0);
        check("t6_mult_idle", 8'(md_busy), 8'd0);
        cyc();
        set_d(1, 0, 3, 0, 3, 8, 1, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t6_mflo_stall_%0d", i), 8'(stall), 8'd1);
            check($sformatf("t6_md_busy_%0d", i), 8'(md_busy), 8'd1);
            cyc();
        end
        check("t6_mflo_release", 8'(stall), 8'd0);
        check("t6_md_done", 8'(md_busy), 8'd0);
        cyc();
        idle(3);

        // divu then mfhi: 10 busy/stall cycles
        set_d(1, 0, 3, 0, 3, 0, 0, 1, 1, 0);
        cyc();
        set_d(1, 0, 3, 0, 3, 8, 1, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t7_mfhi_stall_%0d", i), 8'(stall), 8'd1);
            cyc();
        end
        check("t7_mfhi_release", 8'(stall), 8'd0);
        check("t7_md_done", 8'(md_busy), 8'd0);
        cyc();
        idle(3);

        // load-use stall coinciding with flush: E/M cleared afterwards
        set_d(1, 0, 3, 0, 3, 9, 2, 0, 0, 0);
        cyc();
        set_d(1, 9, 0, 0, 3, 0, 0, 0, 0, 0);
        flush = 1'b1;
        #1;
        check("t8_stall_with_flush", 8'(stall), 8'd1);
        cyc();
        flush = 1'b0;
        #1;
        check("t8_after_flush_stall", 8'(stall), 8'd0);
        check("t8_after_flush_fwd", 8'(fwd_rs_sel), 8'd0);
        idle(3);

        // asynchronous reset in the middle of a mult
        set_d(1, 0, 3, 0, 3, 0, 0, 1, 0, 0);
        cyc();
        set_d(1, 0, 3, 0, 3, 8, 1, 0, 0, 1);
        cyc();
        check("t9_pre_reset_stall", 8'(stall), 8'd1);
        check("t9_pre_reset_busy", 8'(md_busy), 8'd1);
        #1;
        reset = 1'b0;
        #1;
        check("t9_async_stall", 8'(stall), 8'd0);
        check("t9_async_busy", 8'(md_busy), 8'd0);
        cyc();
        reset = 1'b1;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
